// File: rtl/alu_cmd_parser.sv
// Byte-stream command parser feeding the ALU: hunts for a sync byte, collects an
// 8-byte packet, verifies its XOR checksum and presents the fields with a done pulse.
module alu_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [4:0]  operator,
    output logic [3:0]  dtype,
    output logic [15:0] src1,
    output logic [15:0] src2,
    output logic        parser_done,
    output logic        err_fmt,
    output logic        err_chk,
    output logic        err_timeout,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [3:0] {IDLE, OP, DT, S1H, S1L, S2H, S2L, CHK, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  tmo, tmo_nx;
    logic [4:0]  op_sh;
    logic [3:0]  dt_sh;
    logic [15:0] s1_sh, s2_sh;
    logic [7:0]  xsum;
    logic        accept;
    logic        good_nx, fmt_nx, chk_nx, to_nx;

    assign in_ready = (state != DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        tmo_nx   = tmo;
        good_nx  = 1'b0;
        fmt_nx   = 1'b0;
        chk_nx   = 1'b0;
        to_nx    = 1'b0;
        case (state)
            IDLE: begin
                tmo_nx = '0;
                if (accept && in_data == SYNC_BYTE) state_nx = OP;
            end
            DONE: begin
                tmo_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                if (accept) begin
                    tmo_nx = '0;
                    case (state)
                        OP: begin
                            if (in_data[7:5] != '0) begin
                                fmt_nx   = 1'b1;
                                state_nx = IDLE;
                            end else begin
                                state_nx = DT;
                            end
                        end
                        DT: begin
                            if (in_data[7:4] != '0) begin
                                fmt_nx   = 1'b1;
                                state_nx = IDLE;
                            end else begin
                                state_nx = S1H;
                            end
                        end
                        S1H: state_nx = S1L;
                        S1L: state_nx = S2H;
                        S2H: state_nx = S2L;
                        S2L: state_nx = CHK;
                        CHK: begin
                            if (in_data == xsum) begin
                                good_nx  = 1'b1;
                                state_nx = DONE;
                            end else begin
                                chk_nx   = 1'b1;
                                state_nx = IDLE;
                            end
                        end
                        default: state_nx = IDLE;
                    endcase
                end else if (tmo == TMO_LAST) begin
                    to_nx    = 1'b1;
                    tmo_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    tmo_nx = tmo + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmo   <= '0;
        end else begin
            state <= state_nx;
            tmo   <= tmo_nx;
        end
    end

    // Shadow capture; xsum restarts on B1 so it holds XOR of B1..B6 by the time B7 arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            op_sh <= '0;
            dt_sh <= '0;
            s1_sh <= '0;
            s2_sh <= '0;
            xsum  <= '0;
        end else if (accept) begin
            case (state)
                OP:  begin op_sh <= in_data[4:0]; xsum <= in_data; end
                DT:  begin dt_sh <= in_data[3:0]; xsum <= xsum ^ in_data; end
                S1H: begin s1_sh[15:8] <= in_data; xsum <= xsum ^ in_data; end
                S1L: begin s1_sh[7:0]  <= in_data; xsum <= xsum ^ in_data; end
                S2H: begin s2_sh[15:8] <= in_data; xsum <= xsum ^ in_data; end
                S2L: begin s2_sh[7:0]  <= in_data; xsum <= xsum ^ in_data; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            operator    <= '0;
            dtype       <= '0;
            src1        <= '0;
            src2        <= '0;
            parser_done <= 1'b0;
            err_fmt     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            pkt_cnt     <= '0;
            err_cnt     <= '0;
        end else begin
            parser_done <= good_nx;
            err_fmt     <= fmt_nx;
            err_chk     <= chk_nx;
            err_timeout <= to_nx;
            if (good_nx) begin
                operator <= op_sh;
                dtype    <= dt_sh;
                src1     <= s1_sh;
                src2     <= s2_sh;
                pkt_cnt  <= pkt_cnt + 16'd1;
            end
            if ((fmt_nx || chk_nx || to_nx) && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Randomized self-checking bench for alu_cmd_parser against a byte-index packet model.
module tb_alu_cmd_parser;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  operator;
    logic [3:0]  dtype;
    logic [15:0] src1, src2;
    logic        parser_done, err_fmt, err_chk, err_timeout;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    alu_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .operator(operator), .dtype(dtype), .src1(src1), .src2(src2),
        .parser_done(parser_done), .err_fmt(err_fmt), .err_chk(err_chk),
        .err_timeout(err_timeout), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: idx = number of packet bytes held (0 = hunting for sync)
    int          idx, idle;
    logic [7:0]  pb [8];
    logic [4:0]  m_op;
    logic [3:0]  m_dt;
    logic [15:0] m_s1, m_s2, m_pkt;
    logic [7:0]  m_errc;
    logic        m_done, m_efmt, m_echk, m_eto;

    task automatic model_clear();
        idx = 0; idle = 0;
        m_op = '0; m_dt = '0; m_s1 = '0; m_s2 = '0; m_pkt = '0; m_errc = '0;
        m_done = 0; m_efmt = 0; m_echk = 0; m_eto = 0;
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
        logic acc, was_done;
        logic [7:0] x;
        if (r) begin
            model_clear();
            return;
        end
        acc = v && !m_done;
        was_done = m_done;
        m_done = 0; m_efmt = 0; m_echk = 0; m_eto = 0;
        if (was_done) begin
            idx = 0; idle = 0;
        end else if (idx == 0) begin
            idle = 0;
            if (acc && d == 8'hA5) idx = 1;
        end else if (acc) begin
            idle = 0;
            pb[idx] = d;
            if ((idx == 1 && d[7:5] != 0) || (idx == 2 && d[7:4] != 0)) begin
                m_efmt = 1; idx = 0;
            end else if (idx == 7) begin
                x = pb[1] ^ pb[2] ^ pb[3] ^ pb[4] ^ pb[5] ^ pb[6];
                if (x == d) begin
                    m_op = pb[1][4:0]; m_dt = pb[2][3:0];
                    m_s1 = {pb[3], pb[4]}; m_s2 = {pb[5], pb[6]};
                    m_pkt = m_pkt + 16'd1; m_done = 1;
                end else begin
                    m_echk = 1;
                end
                idx = 0;
            end else begin
                idx++;
            end
        end else begin
            idle++;
            if (idle == TMO) begin
                m_eto = 1; idx = 0; idle = 0;
            end
        end
        if ((m_efmt || m_echk || m_eto) && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    endtask

    task automatic check_all();
        check("operator", 32'(operator), 32'(m_op));
        check("dtype", 32'(dtype), 32'(m_dt));
        check("src1", 32'(src1), 32'(m_s1));
        check("src2", 32'(src2), 32'(m_s2));
        check("parser_done", 32'(parser_done), 32'(m_done));
        check("err_fmt", 32'(err_fmt), 32'(m_efmt));
        check("err_chk", 32'(err_chk), 32'(m_echk));
        check("err_timeout", 32'(err_timeout), 32'(m_eto));
        check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
        check("err_cnt", 32'(err_cnt), 32'(m_errc));
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d, output logic acc);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_done));
        acc = v && !m_done && !r;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom), acc);
    endtask

    // Holds the byte until accepted, like a real upstream stream source
    task automatic send_byte(input logic [7:0] d, input int gap);
        logic acc;
        idle_cycles(gap);
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) cycle(1'b0, 1'b1, d, acc);
        if (!acc) check("accept_bound", 32'd0, 32'd1);
    endtask

    task automatic send_seq(input logic [7:0] b [8], input int n);
        for (int i = 0; i < n; i++) send_byte(b[i], 0);
    endtask

    initial begin
        logic acc;
        logic [7:0] p [8];
        model_clear();
        cycle(1'b1, 1'b0, 8'h00, acc);
        cycle(1'b1, 1'b0, 8'h00, acc);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);

        p = '{8'hA5, 8'h01, 8'h01, 8'h12, 8'h34, 8'h00, 8'h34, 8'h12};
        send_seq(p, 8);
        check("tp1_done", 32'(parser_done), 32'd1);
        check("tp1_src1", 32'(src1), 32'h1234);
        check("tp1_src2", 32'(src2), 32'h0034);
        check("tp1_op", 32'(operator), 32'h01);
        check("tp1_pkt", 32'(pkt_cnt), 32'd1);
        check("tp1_ready_done", 32'(in_ready), 32'd0);

        p[7] = 8'h13;
        send_seq(p, 8);
        check("tp2_chk", 32'(err_chk), 32'd1);
        check("tp2_src1_kept", 32'(src1), 32'h1234);
        check("tp2_errcnt", 32'(err_cnt), 32'd1);

        p = '{8'hA5, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(p, 2);
        check("tp3_fmt", 32'(err_fmt), 32'd1);
        p = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h03, 8'h06};
        send_seq(p, 8);
        check("tp3_src1", 32'(src1), 32'h0005);
        check("tp3_src2", 32'(src2), 32'h0003);
        check("tp3_op", 32'(operator), 32'h00);

        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
        send_seq(p, 8);
        check("tp4_done", 32'(parser_done), 32'd1);
        check("tp4_errcnt", 32'(err_cnt), 32'd2);

        send_byte(8'hA5, 1); send_byte(8'h02, 0);
        idle_cycles(TMO);
        check("tp5_timeout", 32'(err_timeout), 32'd1);
        send_seq(p, 8);
        check("tp5_done", 32'(parser_done), 32'd1);

        p = '{8'hA5, 8'h01, 8'h01, 8'h12, 8'h34, 8'h00, 8'h34, 8'h12};
        send_seq(p, 5);
        cycle(1'b1, 1'b0, 8'h00, acc);
        check("tp6_src1", 32'(src1), 32'd0);
        check("tp6_errcnt", 32'(err_cnt), 32'd0);
        send_byte(8'h00, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        send_seq(p, 8);
        check("tp6_pkt", 32'(pkt_cnt), 32'd1);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] q [8];
            int maxgap;
            maxgap = ($urandom_range(0, 9) == 0) ? TMO + 1 : 2;
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(0, 2));
            q[0] = 8'hA5;
            q[1] = {3'b000, 5'($urandom)};
            q[2] = {4'b0000, 4'($urandom)};
            for (int i = 3; i < 7; i++) q[i] = 8'($urandom);
            if ($urandom_range(0, 11) == 0) q[1][5 + $urandom_range(0, 2)] = 1'b1;
            if ($urandom_range(0, 11) == 0) q[2][4 + $urandom_range(0, 3)] = 1'b1;
            if ($urandom_range(0, 5) == 0) q[$urandom_range(3, 6)] = 8'hA5;
            q[7] = q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[5] ^ q[6];
            if ($urandom_range(0, 7) == 0) q[7] = q[7] ^ 8'(1 << $urandom_range(0, 7));
            for (int i = 0; i < 8; i++) send_byte(q[i], $urandom_range(0, maxgap));
            if ($urandom_range(0, 60) == 0) cycle(1'b1, 1'($urandom), 8'hA5, acc);
            if ($urandom_range(0, 4) == 0) cycle(1'b0, 1'b1, 8'($urandom), acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_cmd_parser.md
Name: alu_cmd_parser

Overview:
- Byte-stream command parser sitting directly upstream of the ALU.
- Hunts for a sync byte, then collects operator, dtype, src1 and src2 fields and verifies a checksum.
- On a good packet it presents the fields and pulses parser_done, which is the ALU's start/complete qualifier.
- Bad or stalled packets are discarded and flagged; the ALU-facing fields keep their last good values.

Parameters:
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT, 255, max idle cycles (no accepted byte) allowed mid-packet before abort; must be ≥1, fits 8 bits.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  parser can accept; byte accepted when in_valid&&in_ready at clk edge.
- operator  output  5  ALU operator of last good packet.
- dtype  output  4  ALU data type of last good packet.
- src1  output  16  operand 1 of last good packet.
- src2  output  16  operand 2 of last good packet.
- parser_done  output  1  one-cycle pulse: new good packet on outputs.
- err_fmt  output  1  one-cycle pulse: reserved bits nonzero.
- err_chk  output  1  one-cycle pulse: checksum mismatch.
- err_timeout  output  1  one-cycle pulse: mid-packet timeout.
- pkt_cnt  output  16  good packets, wraps at 16'hFFFF→0.
- err_cnt  output  8  total errors (all three kinds), saturates at 8'hFF.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0 except in_ready=1; FSM=IDLE; timeout counter 0.
- Packet format, 8 bytes in order:
  - B0 = SYNC_BYTE.
  - B1 = {3'b000, operator}.
  - B2 = {4'b0000, dtype}.
  - B3/B4 = src1 MSB then LSB.
  - B5/B6 = src2 MSB then LSB.
  - B7 = XOR of B1..B6.
- FSM states: IDLE, OP, DT, S1H, S1L, S2H, S2L, CHK, DONE. States advance only on accepted bytes.
- IDLE: non-sync bytes are silently dropped (no error). SYNC→OP.
- OP: B1[7:5]≠0 → err_fmt, back to IDLE. DT: B2[7:4]≠0 → err_fmt, back to IDLE.
- Shadow registers capture B1..B6; the output fields are not touched during collection.
- CHK: on match, copy shadows to outputs and go to DONE. On mismatch, err_chk and go to IDLE.
- DONE: lasts exactly 1 cycle with in_ready=0 and parser_done=1; outputs are already updated that same cycle; pkt_cnt increments; then IDLE.
- Latency: parser_done is high in the cycle after the edge that accepts B7.
- in_ready is 1 in every state except DONE. Max throughput is one packet per 9 cycles.
- Timeout: counter clears on every accepted byte and in IDLE/DONE; it increments each cycle in OP..CHK without an accepted byte. When it reaches TIMEOUT: err_timeout pulse, FSM→IDLE, counter cleared.
- Error pulses are registered and high the cycle after detection. err_cnt +1 per pulse, saturating.
- A SYNC_BYTE value received mid-packet is treated as data, not a resync.
- rst asserted mid-packet: FSM→IDLE; output fields, counters and pulses cleared; the partial packet is dropped.
- Output fields stay stable between parser_done pulses; errors never modify them.

Test Plan:
- Reset, then send A5 01 01 12 34 00 34 12 back-to-back → parser_done pulses the cycle after B7; operator=5'h01, dtype=4'h1, src1=16'h1234, src2=16'h0034; pkt_cnt=1.
- Same packet with last byte 13 → err_chk pulse; parser_done stays 0; outputs keep previous values; err_cnt=1.
- A5 21 … (B1[5] set) → err_fmt after B1; a following valid packet A5 00 00 00 05 00 03 06 → src1=5, src2=3, operator=0.
- Leading garbage 00 FF 5A then a valid packet → no error pulses; normal parser_done.
- TIMEOUT=4: send A5 02 and hold in_valid low → err_timeout on the 4th idle cycle; FSM back in IDLE; next full packet parses.
- Assert rst after B4 of a packet → all outputs 0; the tail bytes are dropped as garbage; err_cnt unchanged; a later valid packet gives pkt_cnt=1.
